// File: rtl/id_stage_pkg.sv
// Shared pipeline definitions: field widths, opcode and ALU encodings, and the
// ID/EX pipeline register layout.
package id_stage_pkg;

  localparam int PC_W     = 8;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam int OPC_W    = 6;
  localparam int ALU_W    = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_ADDI = 6'h05,
    OP_LW   = 6'h06,
    OP_SW   = 6'h07,
    OP_BEQ  = 6'h08,
    OP_J    = 6'h09
  } opcode_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_op_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rd;
    alu_op_e           alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, R0 hard-wired to zero.
module reg_file
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: the array is cleared on reset because software may read a register
  // before writing it and expects zero; this costs a reset net per flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0)               ? '0    :
                   (we && waddr == raddr_a)      ? wdata :
                                                   regs[raddr_a];
  assign rdata_b = (raddr_b == '0)               ? '0    :
                   (we && waddr == raddr_b)      ? wdata :
                                                   regs[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode, register read, branch resolution,
// load-use stall detection, branch-shadow squash and the ID/EX register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   IF_ID_PC,
  input  logic [DATA_W-1:0] IF_ID_Instruction,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic [PC_W-1:0]   BranchTarget,
  output logic              BranchTaken,
  output logic              Stall,
  output logic [PC_W-1:0]   ID_EX_PC,
  output logic [DATA_W-1:0] ID_EX_RegA,
  output logic [DATA_W-1:0] ID_EX_RegB,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [REG_W-1:0]  ID_EX_Rd,
  output logic [ALU_W-1:0]  ID_EX_AluOp,
  output logic              ID_EX_AluSrc,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  rd, rs, rt, raddr_b;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              valid, use_a, use_b, b_is_rd, is_beq, is_j;
  logic              alu_src, reg_write, mem_read, mem_write;
  alu_op_e           alu_op;
  logic              hazard, squash;
  id_ex_t            dec, id_ex;

  assign opcode = IF_ID_Instruction[31:26];
  assign rd     = IF_ID_Instruction[25:21];
  assign rs     = IF_ID_Instruction[20:16];
  assign rt     = IF_ID_Instruction[15:11];
  assign imm    = IF_ID_Instruction[15:0];

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    valid = 1'b1; use_a = 1'b0; use_b = 1'b0; b_is_rd = 1'b0;
    is_beq = 1'b0; is_j = 1'b0; alu_op = ALU_ADD; alu_src = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    case (opcode)
      OP_ADD:  begin use_a = 1'b1; use_b = 1'b1; reg_write = 1'b1; end
      OP_SUB:  begin use_a = 1'b1; use_b = 1'b1; reg_write = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin use_a = 1'b1; use_b = 1'b1; reg_write = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin use_a = 1'b1; use_b = 1'b1; reg_write = 1'b1; alu_op = ALU_OR;  end
      OP_ADDI: begin use_a = 1'b1; alu_src = 1'b1; reg_write = 1'b1; end
      OP_LW:   begin use_a = 1'b1; alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
      OP_SW:   begin use_a = 1'b1; use_b = 1'b1; b_is_rd = 1'b1; alu_src = 1'b1; mem_write = 1'b1; end
      OP_BEQ:  begin use_a = 1'b1; use_b = 1'b1; b_is_rd = 1'b1; is_beq = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: valid = 1'b0;
    endcase
  end

  // Port B reads rd for SW (store data) and BEQ (comparand), rt otherwise.
  assign raddr_b = b_is_rd ? rd : rt;

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (WB_RegWrite),
    .waddr   (WB_Rd),
    .wdata   (WB_Data),
    .raddr_a (rs),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // NOP and unknown opcodes load the same all-zero word as a bubble.
  always_comb begin
    dec = '0;
    if (valid) begin
      dec.pc        = IF_ID_PC;
      dec.reg_a     = rdata_a;
      dec.reg_b     = rdata_b;
      dec.imm       = {{(DATA_W-16){imm[15]}}, imm};
      dec.rd        = rd;
      dec.alu_op    = alu_op;
      dec.alu_src   = alu_src;
      dec.reg_write = reg_write;
      dec.mem_read  = mem_read;
      dec.mem_write = mem_write;
    end
  end

  assign hazard = id_ex.mem_read && (id_ex.rd != '0) &&
                  ((use_a && id_ex.rd == rs) || (use_b && id_ex.rd == raddr_b));

  assign Stall        = rst && !squash && hazard;
  assign BranchTaken  = rst && !squash && !hazard &&
                        (is_j || (is_beq && rdata_a == rdata_b));
  assign BranchTarget = is_j ? imm[7:0] : IF_ID_PC + 8'd1 + imm[7:0];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex  <= '0;
      squash <= 1'b0;
    end else begin
      squash <= BranchTaken;
      id_ex  <= (squash || hazard) ? '0 : dec;
    end
  end

  assign ID_EX_PC       = id_ex.pc;
  assign ID_EX_RegA     = id_ex.reg_a;
  assign ID_EX_RegB     = id_ex.reg_b;
  assign ID_EX_Imm      = id_ex.imm;
  assign ID_EX_Rd       = id_ex.rd;
  assign ID_EX_AluOp    = id_ex.alu_op;
  assign ID_EX_AluSrc   = id_ex.alu_src;
  assign ID_EX_RegWrite = id_ex.reg_write;
  assign ID_EX_MemRead  = id_ex.mem_read;
  assign ID_EX_MemWrite = id_ex.mem_write;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random instruction
// streams compared against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_Data;
  logic [7:0]  BranchTarget;
  logic        BranchTaken, Stall;
  logic [7:0]  ID_EX_PC;
  logic [31:0] ID_EX_RegA, ID_EX_RegB, ID_EX_Imm;
  logic [4:0]  ID_EX_Rd;
  logic [2:0]  ID_EX_AluOp;
  logic        ID_EX_AluSrc, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;

  id_stage dut (
    .clk(clk), .rst(rst), .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .BranchTarget(BranchTarget), .BranchTaken(BranchTaken), .Stall(Stall),
    .ID_EX_PC(ID_EX_PC), .ID_EX_RegA(ID_EX_RegA), .ID_EX_RegB(ID_EX_RegB),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_Rd(ID_EX_Rd), .ID_EX_AluOp(ID_EX_AluOp),
    .ID_EX_AluSrc(ID_EX_AluSrc), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic        src, rw, mr, mw;
  } exp_t;

  int total = 0;
  int bad   = 0;

  // Architectural state of the reference model.
  logic [31:0] m_regs [32];
  bit          m_squash;
  bit          m_prev_load;
  logic [4:0]  m_prev_rd;
  bit          last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s, input logic [15:0] lo);
    logic [5:0] o; logic [4:0] dd, ss;
    o = 6'(op); dd = 5'(d); ss = 5'(s);
    return {o, dd, ss, lo};
  endfunction

  function automatic logic [15:0] rt_f(input int t);
    logic [4:0] tt;
    tt = 5'(t);
    return {tt, 11'd0};
  endfunction

  // Register value as seen by decode this cycle, including write-back forwarding.
  function automatic logic [31:0] rval(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (WB_RegWrite && WB_Rd == r) return WB_Data;
    return m_regs[r];
  endfunction

  task automatic model(output exp_t e, output bit stall, output bit taken,
                       output logic [7:0] tgt, output bit is_br);
    logic [5:0] op; logic [4:0] d, s, t; logic [15:0] im;
    logic [4:0] srcs [$];
    op = IF_ID_Instruction[31:26]; d = IF_ID_Instruction[25:21];
    s  = IF_ID_Instruction[20:16]; t = IF_ID_Instruction[15:11];
    im = IF_ID_Instruction[15:0];
    e = '0; stall = 0; taken = 0; tgt = 8'd0; is_br = 0;
    case (op)
      6'd1, 6'd2, 6'd3, 6'd4: srcs = '{s, t};
      6'd5, 6'd6:             srcs = '{s};
      6'd7, 6'd8:             srcs = '{s, d};
      default:                srcs = '{};
    endcase
    if (m_squash) return;
    if (m_prev_load && m_prev_rd != 0)
      foreach (srcs[i]) if (srcs[i] == m_prev_rd) stall = 1;
    if (stall) return;
    if (op >= 6'd1 && op <= 6'd9) begin
      e.pc = IF_ID_PC; e.a = rval(s); e.b = rval(t); e.rd = d;
      e.imm = {{16{im[15]}}, im};
    end
    case (op)
      6'd1, 6'd2, 6'd3, 6'd4: begin e.alu = 3'(op - 6'd1); e.rw = 1; end
      6'd5: begin e.src = 1; e.rw = 1; end
      6'd6: begin e.src = 1; e.rw = 1; e.mr = 1; end
      6'd7: begin e.src = 1; e.mw = 1; e.b = rval(d); end
      6'd8: begin is_br = 1; taken = (rval(d) == rval(s)); tgt = IF_ID_PC + 8'd1 + im[7:0]; end
      6'd9: begin is_br = 1; taken = 1; tgt = im[7:0]; end
      default: ;
    endcase
  endtask

  exp_t       cur_e;
  bit         cur_taken, cur_br;
  logic [7:0] cur_tgt;

  task automatic present(input logic [7:0] pc, input logic [31:0] ins,
                         input bit we, input logic [4:0] wrd, input logic [31:0] wd);
    bit st;
    @(negedge clk);
    IF_ID_PC = pc; IF_ID_Instruction = ins;
    WB_RegWrite = we; WB_Rd = wrd; WB_Data = wd;
    #1;
    model(cur_e, st, cur_taken, cur_tgt, cur_br);
    last_stall = st;
    check("stall", 32'(Stall), 32'(st));
    check("taken", 32'(BranchTaken), 32'(cur_taken));
    if (cur_taken) check("target", 32'(BranchTarget), 32'(cur_tgt));
  endtask

  task automatic commit();
    @(posedge clk);
    if (WB_RegWrite && WB_Rd != 0) m_regs[WB_Rd] = WB_Data;
    m_squash = cur_taken; m_prev_load = cur_e.mr; m_prev_rd = cur_e.rd;
    #1;
    check("id_ex_pc", 32'(ID_EX_PC), 32'(cur_e.pc));
    check("id_ex_rega", ID_EX_RegA, cur_e.a);
    check("id_ex_imm", ID_EX_Imm, cur_e.imm);
    check("id_ex_rw", 32'(ID_EX_RegWrite), 32'(cur_e.rw));
    check("id_ex_mr", 32'(ID_EX_MemRead), 32'(cur_e.mr));
    check("id_ex_mw", 32'(ID_EX_MemWrite), 32'(cur_e.mw));
    if (!cur_br) begin
      check("id_ex_regb", ID_EX_RegB, cur_e.b);
      check("id_ex_rd", 32'(ID_EX_Rd), 32'(cur_e.rd));
      check("id_ex_aluop", 32'(ID_EX_AluOp), 32'(cur_e.alu));
      check("id_ex_alusrc", 32'(ID_EX_AluSrc), 32'(cur_e.src));
    end
  endtask

  task automatic step(input logic [7:0] pc, input logic [31:0] ins,
                      input bit we, input logic [4:0] wrd, input logic [31:0] wd);
    present(pc, ins, we, wrd, wd);
    commit();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(Stall), 32'd0);
    check({tag, "_taken"}, 32'(BranchTaken), 32'd0);
    check({tag, "_idex"}, {ID_EX_PC, ID_EX_Rd, ID_EX_AluOp, ID_EX_AluSrc, ID_EX_RegWrite,
                           ID_EX_MemRead, ID_EX_MemWrite, 12'd0}, 32'd0);
    check({tag, "_data"}, ID_EX_RegA | ID_EX_RegB | ID_EX_Imm, 32'd0);
  endtask

  // Asynchronous reset in the low clock phase, held across one rising edge.
  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_squash = 0; m_prev_load = 0; m_prev_rd = 5'd0;
    @(posedge clk); #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    IF_ID_Instruction = 32'd0; WB_RegWrite = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0]  pc;
    logic [31:0] ins;
    rst = 1'b0; IF_ID_PC = 8'd0; IF_ID_Instruction = 32'd0;
    WB_RegWrite = 1'b0; WB_Rd = 5'd0; WB_Data = 32'd0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_squash = 0; m_prev_load = 0; m_prev_rd = 5'd0; last_stall = 0;
    #1;
    check_reset_outputs("reset_init");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Write-back then ADD r3,r1,r2
    step(8'd0, 32'd0, 1, 5'd1, 32'd5);
    step(8'd1, 32'd0, 1, 5'd2, 32'd7);
    step(8'd2, enc(1, 3, 1, rt_f(2)), 0, 5'd0, 32'd0);
    check("add_rega", ID_EX_RegA, 32'd5);
    check("add_regb", ID_EX_RegB, 32'd7);

    // Bypass on same-cycle write, negative immediate, R0 stays zero
    step(8'd3, enc(5, 5, 4, 16'hFFFF), 1, 5'd4, 32'h1234);
    check("bypass_rega", ID_EX_RegA, 32'h1234);
    check("addi_imm", ID_EX_Imm, 32'hFFFF_FFFF);
    step(8'd4, enc(1, 8, 0, rt_f(0)), 1, 5'd0, 32'hDEAD_BEEF);
    step(8'd5, enc(1, 8, 0, rt_f(0)), 0, 5'd0, 32'd0);
    check("r0_read", ID_EX_RegA, 32'd0);

    // BEQ taken, shadow squash, target wrap
    step(8'd6, 32'd0, 1, 5'd1, 32'd9);
    step(8'd7, 32'd0, 1, 5'd2, 32'd9);
    present(8'd16, enc(8, 1, 2, 16'd4), 0, 5'd0, 32'd0);
    check("beq_target21", 32'(BranchTarget), 32'd21);
    commit();
    step(8'd17, enc(1, 3, 1, rt_f(2)), 0, 5'd0, 32'd0);
    step(8'd250, enc(8, 1, 2, 16'd10), 0, 5'd0, 32'd0);
    step(8'd0, 32'd0, 0, 5'd0, 32'd0);
    present(8'd250, enc(8, 1, 2, 16'd10), 0, 5'd0, 32'd0);
    check("beq_wrap", 32'(BranchTarget), 32'd5);
    commit();
    step(8'd5, 32'd0, 0, 5'd0, 32'd0);

    // Load-use stall then issue
    step(8'd20, enc(6, 6, 0, 16'd0), 0, 5'd0, 32'd0);
    step(8'd21, enc(1, 7, 6, rt_f(1)), 0, 5'd0, 32'd0);
    step(8'd21, enc(1, 7, 6, rt_f(1)), 0, 5'd0, 32'd0);

    // Load followed by dependent BEQ: held off for one cycle, then resolved
    step(8'd30, enc(6, 1, 0, 16'd0), 0, 5'd0, 32'd0);
    step(8'd31, enc(8, 1, 2, 16'd2), 0, 5'd0, 32'd0);
    step(8'd31, enc(8, 1, 2, 16'd2), 0, 5'd0, 32'd0);
    step(8'd34, 32'd0, 0, 5'd0, 32'd0);

    // Reset asserted mid-stall
    step(8'd40, enc(6, 6, 0, 16'd0), 0, 5'd0, 32'd0);
    present(8'd41, enc(1, 7, 6, rt_f(1)), 0, 5'd0, 32'd0);
    async_reset("reset_stall");

    // Reset asserted mid-squash (R1==R2==0 after reset, so BEQ is taken)
    step(8'd50, enc(8, 1, 2, 16'd3), 0, 5'd0, 32'd0);
    present(8'd51, enc(1, 3, 1, rt_f(2)), 0, 5'd0, 32'd0);
    async_reset("reset_squash");
    step(8'd60, enc(1, 3, 1, rt_f(2)), 1, 5'd1, 32'd11);

    // Random instruction stream over a small register window to provoke hazards
    pc = 8'd0; ins = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        pc  = 8'($urandom_range(0, 255));
        ins = {6'($urandom_range(0, 12)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom)};
      end
      step(pc, ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
